demux_5_sync: RTL and testbench
===============================

Name: demux_5_sync

Overview:
Registered 1-to-5 sample demultiplexer for the DDS datapath; the inverse of the 5-input waveform mux. It routes one sample stream to one of five channel outputs. The channel select is double-buffered and changes only on a frame_sync pulse (phase-accumulator wrap), so a channel never receives a partial waveform period. It sits between the DDS waveform generator and the per-channel output stages (DAC/PWM/mixer inputs).

Parameters:
m, 12, sample width in bits
RST_SEL, 0, channel selected after reset (0..4)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_data  input  m  sample to route
in_valid  input  1  in_data valid this cycle
sel_req  input  3  requested channel (0..4 legal; 5..7 illegal)
sel_load  input  1  capture sel_req into the pending register
frame_sync  input  1  one-cycle pulse at phase wrap; applies the pending select
out0..out4  output  m each  registered channel samples
out_valid  output  5  one-hot, one-cycle strobe of the written channel
sel_active  output  3  currently applied channel
sel_pending  output  1  a loaded select is waiting for frame_sync
sel_err  output  1  sticky: an illegal sel_req was loaded

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out0..out4 = 0, out_valid = 0, sel_active = RST_SEL, sel_pending = 0, pending register = RST_SEL, sel_err = 0, FSM = IDLE.
- Datapath latency is 1 cycle. When in_valid=1 at edge N, at edge N:
  - out[sel_active] <= in_data.
  - out_valid <= one-hot(sel_active).
- When in_valid=0, out_valid <= 0 and all outputs hold.
- Non-selected outputs hold their last value (see Optional Feature).
- Select FSM, 2 states:
  - IDLE: sel_load with legal sel_req -> pending <= sel_req, go to PENDING. sel_load with illegal sel_req -> sel_err <= 1, stay in IDLE, pending unchanged.
  - PENDING: sel_load with legal sel_req -> pending overwritten (newest wins), stay. frame_sync -> sel_active <= pending, go to IDLE.
  - sel_pending = (state == PENDING).
- Simultaneous sel_load (legal) and frame_sync in one cycle, either state: sel_active <= sel_req directly (bypass), go to IDLE.
- Simultaneous sel_load (illegal) and frame_sync in PENDING: the old pending value is applied; sel_err is set.
- frame_sync in IDLE with no sel_load: no effect.
- Simultaneous in_valid and a select switch: the sample is routed using the pre-switch sel_active. The new channel takes effect on the next in_valid.
- Selecting the channel already active is legal. It still passes through PENDING and still applies on frame_sync.
- sel_err is cleared only by a subsequent legal sel_load, or by reset.
- Reset asserted mid-operation: a pending select is discarded, all outputs return to reset values immediately (asynchronously), and no out_valid strobe is emitted.
- sel_active is always in 0..4. The default branch of the routing logic is unreachable but must hold outputs.

Optional Feature:
Macro DEMUX_ZERO_UNSEL_EN.
- Defined: on the cycle sel_active changes to a different value, the output of the previously active channel is cleared to 0 (on the same edge). Idle channels therefore read 0.
- Not defined: a deselected channel holds its last sample indefinitely.
- out_valid behaviour is identical in both builds.

Decomposition:
- Shared package dds_pkg holds:
  - SEL_W = 3 and NUM_CH = 5.
  - Channel encodings CH_SINE=0, CH_SQUARE=1, CH_TRI=2, CH_SAW=3, CH_NOISE=4.
  - The FSM state typedef {IDLE, PENDING}.
  - The helper constant SEL_MAX = 4 for the legality check.
- One sub-module is natural: demux_sel_ctrl. It contains the FSM, the pending register, sel_err and the bypass logic, and outputs sel_active and sel_pending. The top level holds only the routing registers and out_valid.

Test Plan:
- Reset, then in_valid=1, in_data=12'hABC (RST_SEL=0) -> next cycle out0=ABC, out_valid=5'b00001, out1..4=0.
- sel_load with sel_req=3, then 4 samples 1,2,3,4 before frame_sync -> all four land on out0. sel_pending=1 throughout. After frame_sync: sel_active=3, sel_pending=0, next sample 5 -> out3=5, out_valid=5'b01000.
- sel_load 2 then sel_load 4 while PENDING, then frame_sync -> sel_active=4 (newest wins). out2 is never written.
- sel_load 7 -> sel_err=1, sel_pending=0, sel_active unchanged. Then sel_load 1 plus frame_sync in the same cycle -> sel_err=0, sel_active=1 (bypass).
- in_valid with in_data=12'h123 on the same cycle as a frame_sync switching 0->2 -> out0=123. The next sample goes to out2. With DEMUX_ZERO_UNSEL_EN defined, out0=0 after the switch instead.
- rst_n pulsed low for 1 ns mid-PENDING (sel_req=4 loaded) -> immediately sel_active=0, sel_pending=0, outputs 0. A later frame_sync changes nothing.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS datapath definitions: channel encodings, select width and FSM states.
package dds_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 5;

    localparam logic [SEL_W-1:0] CH_SINE   = 3'd0;
    localparam logic [SEL_W-1:0] CH_SQUARE = 3'd1;
    localparam logic [SEL_W-1:0] CH_TRI    = 3'd2;
    localparam logic [SEL_W-1:0] CH_SAW    = 3'd3;
    localparam logic [SEL_W-1:0] CH_NOISE  = 3'd4;

    // Highest legal channel code; anything above is rejected by the select FSM.
    localparam logic [SEL_W-1:0] SEL_MAX = CH_NOISE;

    typedef enum logic {
        IDLE,
        PENDING
    } sel_state_e;

endpackage

// File: rtl/demux_sel_ctrl.sv
// Double-buffered channel select for demux_5_sync: pending register, frame_sync apply, bypass, sticky error.
// Exposes sel_change only when DEMUX_ZERO_UNSEL_EN is defined.
module demux_sel_ctrl
    import dds_pkg::*;
#(
    parameter int RST_SEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             sel_load,
    input  logic             frame_sync,
    output logic [SEL_W-1:0] sel_active,
    output logic             sel_err,
`ifdef DEMUX_ZERO_UNSEL_EN
    output logic             sel_change,
`endif
    output logic             sel_pending
);

    localparam logic [SEL_W-1:0] RST_VAL = SEL_W'(RST_SEL);

    sel_state_e       state;
    logic [SEL_W-1:0] pending;
    logic             load_ok;

    assign load_ok     = sel_load && (sel_req <= SEL_MAX);
    assign sel_pending = (state == PENDING);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= RST_VAL;
            sel_active <= RST_VAL;
            sel_err    <= 1'b0;
        end else begin
            if (sel_load) begin
                sel_err <= !load_ok;
            end
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        if (frame_sync) begin
                            sel_active <= sel_req;
                        end else begin
                            pending <= sel_req;
                            state   <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (frame_sync) begin
                        sel_active <= load_ok ? sel_req : pending;
                        state      <= IDLE;
                    end else if (load_ok) begin
                        pending <= sel_req;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX_ZERO_UNSEL_EN
    logic [SEL_W-1:0] sel_next;

    // Value sel_active takes at the coming edge; lets the datapath clear the outgoing channel on that edge.
    always_comb begin
        sel_next = sel_active;
        if (frame_sync) begin
            if (load_ok) begin
                sel_next = sel_req;
            end else if (state == PENDING) begin
                sel_next = pending;
            end
        end
        sel_change = (sel_next != sel_active);
    end
`endif

endmodule

// File: rtl/demux_5_sync.sv
// Registered 1-to-5 sample demultiplexer with frame-synchronised channel switching.
// Define DEMUX_ZERO_UNSEL_EN to clear a channel's output when it is deselected.
module demux_5_sync
    import dds_pkg::*;
#(
    parameter int m       = 12,
    parameter int RST_SEL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [m-1:0]      in_data,
    input  logic              in_valid,
    input  logic [SEL_W-1:0]  sel_req,
    input  logic              sel_load,
    input  logic              frame_sync,
    output logic [m-1:0]      out0,
    output logic [m-1:0]      out1,
    output logic [m-1:0]      out2,
    output logic [m-1:0]      out3,
    output logic [m-1:0]      out4,
    output logic [NUM_CH-1:0] out_valid,
    output logic [SEL_W-1:0]  sel_active,
    output logic              sel_pending,
    output logic              sel_err
);

    logic [m-1:0] out_reg [NUM_CH];
`ifdef DEMUX_ZERO_UNSEL_EN
    logic sel_change;
`endif

    demux_sel_ctrl #(
        .RST_SEL (RST_SEL)
    ) u_sel_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_req     (sel_req),
        .sel_load    (sel_load),
        .frame_sync  (frame_sync),
        .sel_active  (sel_active),
        .sel_err     (sel_err),
`ifdef DEMUX_ZERO_UNSEL_EN
        .sel_change  (sel_change),
`endif
        .sel_pending (sel_pending)
    );

    // Routing uses the pre-switch sel_active; a code outside 0..4 matches no channel and everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the channel array is a handful of flops, not a RAM, so resetting every entry is cheap and required.
            for (int i = 0; i < NUM_CH; i++) begin
                out_reg[i] <= '0;
            end
            out_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_valid[i] <= in_valid && (sel_active == SEL_W'(i));
                if (in_valid && (sel_active == SEL_W'(i))) begin
                    out_reg[i] <= in_data;
                end
`ifdef DEMUX_ZERO_UNSEL_EN
                if (sel_change && (sel_active == SEL_W'(i))) begin
                    out_reg[i] <= '0;
                end
`endif
            end
        end
    end

    assign out0 = out_reg[0];
    assign out1 = out_reg[1];
    assign out2 = out_reg[2];
    assign out3 = out_reg[3];
    assign out4 = out_reg[4];

endmodule

// File: tb/tb_demux_5_sync.sv
// Self-checking bench for demux_5_sync: behavioural model feeds a scoreboard, compared one cycle later.
// Honours DEMUX_ZERO_UNSEL_EN when it is defined for the build.
module tb_demux_5_sync;

    logic        clk;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic [2:0]  sel_req;
    logic        sel_load;
    logic        frame_sync;
    logic [11:0] out0, out1, out2, out3, out4;
    logic [4:0]  out_valid;
    logic [2:0]  sel_active;
    logic        sel_pending;
    logic        sel_err;

    int passed = 0;
    int total  = 0;

    demux_5_sync #(
        .m       (12),
        .RST_SEL (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .sel_req     (sel_req),
        .sel_load    (sel_load),
        .frame_sync  (frame_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .out_valid   (out_valid),
        .sel_active  (sel_active),
        .sel_pending (sel_pending),
        .sel_err     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0][11:0] outs;
        logic [4:0]       valid;
        logic [2:0]       active;
        logic             pend;
        logic             err;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [4:0][11:0] m_outs;
    logic [4:0]       m_valid;
    logic [2:0]       m_active;
    logic [2:0]       m_pval;
    logic             m_pend;
    logic             m_err;

    logic [4:0][11:0] dut_outs;
    assign dut_outs = {out4, out3, out2, out1, out0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_outs   = '0;
        m_valid  = '0;
        m_active = 3'd0;
        m_pval   = 3'd0;
        m_pend   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".valid"},   32'(out_valid),   32'(e.valid));
        check({tag, ".active"},  32'(sel_active),  32'(e.active));
        check({tag, ".pending"}, 32'(sel_pending), 32'(e.pend));
        check({tag, ".err"},     32'(sel_err),     32'(e.err));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s.out%0d", tag, i), 32'(dut_outs[i]), 32'(e.outs[i]));
        end
    endtask

    // One clock of stimulus: drive, predict, push, then pop and compare after the edge.
    task automatic step(input string tag, input logic [11:0] data, input logic valid,
                        input logic [2:0] req, input logic load, input logic fs);
        exp_t       e;
        logic       legal;
        logic [2:0] nxt;
        in_data    = data;
        in_valid   = valid;
        sel_req    = req;
        sel_load   = load;
        frame_sync = fs;

        legal = (req <= 3'd4);
        nxt   = m_active;
        if (fs && load && legal) nxt = req;
        else if (fs && m_pend)   nxt = m_pval;

        m_valid = '0;
        if (valid) begin
            m_outs[m_active] = data;
            m_valid          = 5'(1) << m_active;
        end
`ifdef DEMUX_ZERO_UNSEL_EN
        if (nxt != m_active) m_outs[m_active] = '0;
`endif
        if (load) m_err = !legal;
        if (fs && (m_pend || (load && legal))) begin
            m_pend = 1'b0;
        end else if (load && legal) begin
            m_pend = 1'b1;
            m_pval = req;
        end
        m_active = nxt;

        e.outs   = m_outs;
        e.valid  = m_valid;
        e.active = m_active;
        e.pend   = m_pend;
        e.err    = m_err;
        sb.push_back(e);

        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        sel_load   = 1'b0;
        frame_sync = 1'b0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            compare_all(tag, e);
        end
    endtask

    initial begin
        exp_t r;
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        sel_req    = '0;
        sel_load   = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        r = '{outs: '0, valid: '0, active: 3'd0, pend: 1'b0, err: 1'b0};
        compare_all("reset", r);
        rst_n = 1'b1;

        // First sample lands on the reset channel
        step("first", 12'hABC, 1'b1, 3'd0, 1'b0, 1'b0);
        check("first.const_out0", 32'(out0), 32'h0ABC);
        check("first.const_valid", 32'(out_valid), 32'b00001);

        // Pending select does not move samples until frame_sync
        step("load3", 12'h000, 1'b0, 3'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("pend_s%0d", k), 12'(k), 1'b1, 3'd0, 1'b0, 1'b0);
        end
        check("pend.const_out0", 32'(out0), 32'h4);
        step("fs3", 12'h000, 1'b0, 3'd0, 1'b0, 1'b1);
        step("s5", 12'h005, 1'b1, 3'd0, 1'b0, 1'b0);
        check("s5.const_out3", 32'(out3), 32'h5);
        check("s5.const_valid", 32'(out_valid), 32'b01000);

        // Newest pending wins; channel 2 never written
        step("load2", 12'h000, 1'b0, 3'd2, 1'b1, 1'b0);
        step("load4", 12'h000, 1'b0, 3'd4, 1'b1, 1'b0);
        step("fs4", 12'h000, 1'b0, 3'd0, 1'b0, 1'b1);
        step("s4_data", 12'h777, 1'b1, 3'd0, 1'b0, 1'b0);
        check("newest.const_active", 32'(sel_active), 32'd4);
        check("newest.const_out2", 32'(out2), 32'h0);

        // Illegal select sets sticky error; legal bypass clears it
        step("load7", 12'h000, 1'b0, 3'd7, 1'b1, 1'b0);
        check("err.const_err", 32'(sel_err), 32'd1);
        step("fs_idle", 12'h000, 1'b0, 3'd0, 1'b0, 1'b1);
        step("bypass1", 12'h000, 1'b0, 3'd1, 1'b1, 1'b1);
        check("bypass.const_active", 32'(sel_active), 32'd1);
        check("bypass.const_err", 32'(sel_err), 32'd0);

        // Illegal load with frame_sync in PENDING applies the old pending value
        step("load3b", 12'h000, 1'b0, 3'd3, 1'b1, 1'b0);
        step("ill_fs", 12'h000, 1'b0, 3'd6, 1'b1, 1'b1);
        check("ill_fs.const_active", 32'(sel_active), 32'd3);
        // Reselecting the active channel still passes through PENDING
        step("same3", 12'h000, 1'b0, 3'd3, 1'b1, 1'b0);
        check("same3.const_pend", 32'(sel_pending), 32'd1);
        step("same3_fs", 12'h000, 1'b0, 3'd0, 1'b0, 1'b1);

        // Sample coincident with a 0->2 switch uses the old channel
        step("bypass0", 12'h000, 1'b0, 3'd0, 1'b1, 1'b1);
        step("load2b", 12'h000, 1'b0, 3'd2, 1'b1, 1'b0);
        step("sw_sample", 12'h123, 1'b1, 3'd0, 1'b0, 1'b1);
`ifdef DEMUX_ZERO_UNSEL_EN
        check("sw.const_out0", 32'(out0), 32'h0);
`else
        check("sw.const_out0", 32'(out0), 32'h123);
`endif
        check("sw.const_valid", 32'(out_valid), 32'b00001);
        step("after_sw", 12'h456, 1'b1, 3'd0, 1'b0, 1'b0);
        check("after_sw.const_out2", 32'(out2), 32'h456);

        // Asynchronous reset mid-PENDING discards the pending select
        step("load4b", 12'h000, 1'b0, 3'd4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        r = '{outs: '0, valid: '0, active: 3'd0, pend: 1'b0, err: 1'b0};
        compare_all("async_rst", r);
        rst_n = 1'b1;
        @(negedge clk);
        step("fs_after_rst", 12'h000, 1'b0, 3'd0, 1'b0, 1'b1);
        check("fs_after_rst.const_active", 32'(sel_active), 32'd0);
        step("post_rst_sample", 12'h9A5, 1'b1, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
